// File: rtl/job_collector_pkg.sv
// job_collector_pkg: header field positions, type codes, word-count helpers and FSM states shared by the job collector
package job_collector_pkg;
  localparam int LAST_BIT = 47;
  localparam int TYPE_HI = 46;
  localparam int TYPE_LO = 44;
  localparam int IDX_HI = 43;
  localparam int IDX_LO = 40;
  localparam logic [2:0] TYPE_IDLE = 3'd0;
  localparam logic [2:0] TYPE_DATA = 3'd1;
  localparam logic [2:0] TYPE_MID = 3'd2;
  localparam logic [2:0] TYPE_TGT = 3'd3;
  localparam logic [2:0] TYPE_ABORT = 3'd7;
  typedef enum logic {COLLECT, PENDING} state_e;
  function automatic int nwords(input int width, input int p);
    return (width + p - 1) / p;
  endfunction
  function automatic int remwidth(input int width, input int p);
    return width % p;
  endfunction
endpackage

// File: rtl/job_collector_field_assembler.sv
// field_assembler: one MSB-first shadow field plus received mask; in: word type/index/payload, accept, clear; out: hit, tail, complete, next shadow value
module field_assembler
  import job_collector_pkg::*;
#(
  parameter int W = 96,
  parameter int P = 40,
  parameter logic [2:0] TYPE = TYPE_DATA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         acc_i,
  input  logic [2:0]   typ_i,
  input  logic [3:0]   idx_i,
  input  logic [P-1:0] payload_i,
  input  logic         clr_i,
  output logic         hit_o,
  output logic         tail_o,
  output logic         complete_o,
  output logic [W-1:0] data_nxt_o
);
  localparam int NW = nwords(W, P);
  localparam int R = remwidth(W, P);
  localparam int RR = R == 0 ? 1 : R;
  localparam int NF = R == 0 ? NW : NW - 1;
  logic [W-1:0] data_q, data_d;
  logic [NW-1:0] mask_q, mask_d, mask_w;
  logic wr;
  assign hit_o = typ_i == TYPE && idx_i != 4'd0 && idx_i <= 4'(NW);
  assign tail_o = hit_o && idx_i == 4'(NW);
  assign wr = acc_i && hit_o;
  assign complete_o = &mask_w;
  assign data_nxt_o = data_d;
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < NF; k++)
      if (wr && idx_i == 4'(k + 1)) data_d[W-1-k*P -: P] = payload_i;
    if (R != 0 && wr && idx_i == 4'(NW)) data_d[RR-1:0] = payload_i[P-1 -: RR];
    mask_w = wr ? mask_q | NW'(1) << (idx_i - 4'd1) : mask_q;
    mask_d = clr_i ? '0 : mask_w;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end
endmodule

// File: rtl/job_collector.sv
// job_collector: assembles tagged words into data_hash/midstate/target jobs; in: datain stream, job_ready; out: datain_ready, job fields, job_valid, error pulses, job_cnt
module job_collector
  import job_collector_pkg::*;
#(
  parameter int DATAIN = 48,
  parameter int PAYLOAD_WID = 40,
  parameter int DATA_WID = 96,
  parameter int HASH_DATA_WID = 256,
  parameter int CNT_WID = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     datain_valid,
  input  logic [DATAIN-1:0]        datain,
  output logic                     datain_ready,
  output logic                     job_valid,
  input  logic                     job_ready,
  output logic [DATA_WID-1:0]      data_hash,
  output logic [HASH_DATA_WID-1:0] midstate,
  output logic [HASH_DATA_WID-1:0] target,
  output logic                     err_incomplete,
  output logic                     err_bad_word,
  output logic [CNT_WID-1:0]       job_cnt
);
  state_e state_q, state_d;
  logic up_q, vld_q, vld_d, inc_q, bad_q;
  logic [CNT_WID-1:0] cnt_q;
  logic [DATA_WID-1:0] dh_q, nxt_d;
  logic [HASH_DATA_WID-1:0] ms_q, tg_q, nxt_m, nxt_t;
  logic acc, last, hit_d, hit_m, hit_t, tail_d, tail_m, tail_t, cmp_d, cmp_m, cmp_t;
  logic all_cmp, try_commit, good, inc, bad, abort, free, take, load, clr;
  logic [2:0] typ;
  logic [3:0] idx;
  logic [PAYLOAD_WID-1:0] pl;
  assign datain_ready = up_q && state_q == COLLECT;
  assign acc = datain_valid && datain_ready;
  assign last = datain[LAST_BIT];
  assign typ = datain[TYPE_HI:TYPE_LO];
  assign idx = datain[IDX_HI:IDX_LO];
  assign pl = datain[PAYLOAD_WID-1:0];
  field_assembler #(.W(DATA_WID), .P(PAYLOAD_WID), .TYPE(TYPE_DATA)) u_data (
    .clk(clk), .rst_n(rst_n), .acc_i(acc), .typ_i(typ), .idx_i(idx), .payload_i(pl), .clr_i(clr),
    .hit_o(hit_d), .tail_o(tail_d), .complete_o(cmp_d), .data_nxt_o(nxt_d)
  );
  field_assembler #(.W(HASH_DATA_WID), .P(PAYLOAD_WID), .TYPE(TYPE_MID)) u_mid (
    .clk(clk), .rst_n(rst_n), .acc_i(acc), .typ_i(typ), .idx_i(idx), .payload_i(pl), .clr_i(clr),
    .hit_o(hit_m), .tail_o(tail_m), .complete_o(cmp_m), .data_nxt_o(nxt_m)
  );
  field_assembler #(.W(HASH_DATA_WID), .P(PAYLOAD_WID), .TYPE(TYPE_TGT)) u_tgt (
    .clk(clk), .rst_n(rst_n), .acc_i(acc), .typ_i(typ), .idx_i(idx), .payload_i(pl), .clr_i(clr),
    .hit_o(hit_t), .tail_o(tail_t), .complete_o(cmp_t), .data_nxt_o(nxt_t)
  );
  // completeness is judged on masks that already include the current word
  assign all_cmp = cmp_d && cmp_m && cmp_t;
  // the target tail always commits; other field tails commit only when they finish the job
  assign try_commit = acc && last && (tail_t || ((tail_d || tail_m) && all_cmp));
  assign good = try_commit && all_cmp;
  assign inc = try_commit && !all_cmp;
  assign bad = acc && !(typ == TYPE_IDLE || typ == TYPE_ABORT || hit_d || hit_m || hit_t);
  assign abort = acc && typ == TYPE_ABORT;
  assign free = !vld_q || job_ready;
  assign take = vld_q && job_ready;
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    clr = abort || inc;
    if (state_q == COLLECT && good) begin
      load = free;
      clr = clr || free;
      state_d = free ? COLLECT : PENDING;
    end
    if (state_q == PENDING && job_ready) begin
      load = 1'b1;
      clr = 1'b1;
      state_d = COLLECT;
    end
    vld_d = load || (vld_q && !take);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      up_q <= 1'b0;
      vld_q <= 1'b0;
      inc_q <= 1'b0;
      bad_q <= 1'b0;
      cnt_q <= '0;
      dh_q <= '0;
      ms_q <= '0;
      tg_q <= '0;
    end else begin
      state_q <= state_d;
      up_q <= 1'b1;
      vld_q <= vld_d;
      inc_q <= inc;
      bad_q <= bad;
      cnt_q <= cnt_q + CNT_WID'(take);
      if (load) begin
        dh_q <= nxt_d;
        ms_q <= nxt_m;
        tg_q <= nxt_t;
      end
    end
  end
  assign job_valid = vld_q;
  assign data_hash = dh_q;
  assign midstate = ms_q;
  assign target = tg_q;
  assign err_incomplete = inc_q;
  assign err_bad_word = bad_q;
  assign job_cnt = cnt_q;
endmodule

// File: tb/tb_job_collector.sv
// tb_job_collector: directed scenario tasks checking job assembly, errors, backpressure, abort and reset against hand-built expected jobs
module tb_job_collector;
  logic clk = 1'b0, rst_n = 1'b0, datain_valid = 1'b0, job_ready = 1'b0;
  logic [47:0] datain = '0;
  logic datain_ready, job_valid, err_incomplete, err_bad_word;
  logic [95:0] data_hash;
  logic [255:0] midstate, target;
  logic [15:0] job_cnt;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  job_collector dut (
    .clk(clk), .rst_n(rst_n), .datain_valid(datain_valid), .datain(datain), .datain_ready(datain_ready),
    .job_valid(job_valid), .job_ready(job_ready), .data_hash(data_hash), .midstate(midstate), .target(target),
    .err_incomplete(err_incomplete), .err_bad_word(err_bad_word), .job_cnt(job_cnt)
  );
  function automatic logic [39:0] pl(input int s, input int t, input int k);
    return {8'(s), 4'(t), 4'(k), 24'(s * 'h13579 + t * 'h0a0b0 + k * 'h777)};
  endfunction
  function automatic logic [95:0] exp_dh(input int s);
    logic [39:0] w;
    w = pl(s, 1, 3);
    return {pl(s, 1, 1), pl(s, 1, 2), w[39:24]};
  endfunction
  function automatic logic [255:0] exp_h(input int s, input int t);
    logic [39:0] w;
    w = pl(s, t, 7);
    return {pl(s, t, 1), pl(s, t, 2), pl(s, t, 3), pl(s, t, 4), pl(s, t, 5), pl(s, t, 6), w[39:24]};
  endfunction
  task automatic send_word(input logic l, input int t, input int k, input logic [39:0] p);
    int n = 0;
    @(negedge clk);
    datain_valid = 1'b1;
    datain = {l, 3'(t), 4'(k), p};
    while (!datain_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!datain_ready) begin
      total++;
      $display("FAIL send_ready_timeout: datain_ready=%b required 1", datain_ready);
    end
    @(posedge clk);
    #1 datain_valid = 1'b0;
  endtask
  task automatic send_job(input int s, input int st, input int sk);
    for (int t = 1; t <= 3; t++)
      for (int k = 1; k <= (t == 1 ? 3 : 7); k++)
        if (!(t == st && k == sk)) send_word(t == 3 && k == 7, t, k, pl(s, t, k));
  endtask
  task automatic take_job();
    @(negedge clk);
    job_ready = 1'b1;
    @(posedge clk);
    #1 job_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (datain_ready !== 1'b0 || job_valid !== 1'b0) $display("FAIL reset_hold: ready=%b valid=%b required 0 0", datain_ready, job_valid);
    else pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (datain_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", datain_ready);
    else pass++;
    total++;
    if ({job_valid, err_incomplete, err_bad_word, job_cnt} !== 19'd0 || {data_hash, midstate, target} !== '0)
      $display("FAIL reset_state: valid=%b inc=%b bad=%b cnt=%0d required all 0", job_valid, err_incomplete, err_bad_word, job_cnt);
    else pass++;
  endtask
  task automatic test_full_job();
    logic [39:0] w;
    w = pl(1, 3, 7);
    send_job(1, 0, 0);
    total++;
    if (job_valid !== 1'b1) $display("FAIL full_valid: got %b required 1", job_valid);
    else pass++;
    total++;
    if ({data_hash, midstate, target} !== {exp_dh(1), exp_h(1, 2), exp_h(1, 3)})
      $display("FAIL full_fields: dh=%h required %h", data_hash, exp_dh(1));
    else pass++;
    total++;
    if (target[15:0] !== w[39:24]) $display("FAIL full_tgt_tail: got %h required %h", target[15:0], w[39:24]);
    else pass++;
    total++;
    if (job_cnt !== 16'd0) $display("FAIL full_cnt_before: got %0d required 0", job_cnt);
    else pass++;
    take_job();
    total++;
    if (job_cnt !== 16'd1 || job_valid !== 1'b0) $display("FAIL full_handshake: cnt=%0d valid=%b required 1 0", job_cnt, job_valid);
    else pass++;
  endtask
  task automatic test_missing();
    send_job(2, 2, 4);
    total++;
    if (err_incomplete !== 1'b1 || job_valid !== 1'b0) $display("FAIL missing_err: inc=%b valid=%b required 1 0", err_incomplete, job_valid);
    else pass++;
    @(posedge clk);
    #1;
    total++;
    if (err_incomplete !== 1'b0) $display("FAIL missing_pulse: inc=%b required 0", err_incomplete);
    else pass++;
    send_job(3, 0, 0);
    total++;
    if (job_valid !== 1'b1 || {data_hash, midstate, target} !== {exp_dh(3), exp_h(3, 2), exp_h(3, 3)})
      $display("FAIL missing_recover: valid=%b dh=%h required 1 %h", job_valid, data_hash, exp_dh(3));
    else pass++;
    take_job();
    total++;
    if (job_cnt !== 16'd2) $display("FAIL missing_cnt: got %0d required 2", job_cnt);
    else pass++;
  endtask
  task automatic test_back_to_back();
    send_job(4, 0, 0);
    send_job(5, 0, 0);
    total++;
    if (datain_ready !== 1'b0 || job_valid !== 1'b1 || data_hash !== exp_dh(4))
      $display("FAIL bp_pending: ready=%b valid=%b dh=%h required 0 1 %h", datain_ready, job_valid, data_hash, exp_dh(4));
    else pass++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (job_valid !== 1'b1 || {data_hash, midstate, target} !== {exp_dh(4), exp_h(4, 2), exp_h(4, 3)})
      $display("FAIL bp_stable: valid=%b dh=%h required 1 %h", job_valid, data_hash, exp_dh(4));
    else pass++;
    @(negedge clk) job_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (job_valid !== 1'b1 || {data_hash, midstate, target} !== {exp_dh(5), exp_h(5, 2), exp_h(5, 3)})
      $display("FAIL bp_second: valid=%b dh=%h required 1 %h", job_valid, data_hash, exp_dh(5));
    else pass++;
    total++;
    if (job_cnt !== 16'd3 || datain_ready !== 1'b1) $display("FAIL bp_release: cnt=%0d ready=%b required 3 1", job_cnt, datain_ready);
    else pass++;
    @(posedge clk);
    #1;
    total++;
    if (job_cnt !== 16'd4 || job_valid !== 1'b0) $display("FAIL bp_done: cnt=%0d valid=%b required 4 0", job_cnt, job_valid);
    else pass++;
    job_ready = 1'b0;
  endtask
  task automatic test_bad_words();
    send_job(6, 3, 7);
    send_word(1'b0, 1, 4, 40'hDE_ADBE_EF00);
    total++;
    if (err_bad_word !== 1'b1) $display("FAIL bad_idx: err=%b required 1", err_bad_word);
    else pass++;
    send_word(1'b0, 5, 1, 40'h12_3456_789A);
    total++;
    if (err_bad_word !== 1'b1) $display("FAIL bad_type: err=%b required 1", err_bad_word);
    else pass++;
    send_word(1'b0, 2, 8, 40'hFF_FFFF_FFFF);
    total++;
    if (err_bad_word !== 1'b1) $display("FAIL bad_mid_idx: err=%b required 1", err_bad_word);
    else pass++;
    send_word(1'b1, 3, 7, pl(6, 3, 7));
    total++;
    if (err_bad_word !== 1'b0 || err_incomplete !== 1'b0) $display("FAIL bad_clear: bad=%b inc=%b required 0 0", err_bad_word, err_incomplete);
    else pass++;
    total++;
    if (job_valid !== 1'b1 || {data_hash, midstate, target} !== {exp_dh(6), exp_h(6, 2), exp_h(6, 3)})
      $display("FAIL bad_shadow: valid=%b dh=%h required 1 %h", job_valid, data_hash, exp_dh(6));
    else pass++;
    take_job();
  endtask
  task automatic test_abort();
    for (int k = 1; k <= 3; k++) send_word(1'b0, 1, k, pl(7, 1, k));
    for (int k = 1; k <= 4; k++) send_word(1'b0, 2, k, pl(7, 2, k));
    send_word(1'b0, 7, 0, 40'd0);
    total++;
    if (err_bad_word !== 1'b0) $display("FAIL abort_noerr: err=%b required 0", err_bad_word);
    else pass++;
    send_job(8, 2, 4);
    total++;
    if (err_incomplete !== 1'b1 || job_valid !== 1'b0) $display("FAIL abort_masks: inc=%b valid=%b required 1 0", err_incomplete, job_valid);
    else pass++;
    send_job(9, 0, 0);
    total++;
    if (job_valid !== 1'b1 || {data_hash, midstate, target} !== {exp_dh(9), exp_h(9, 2), exp_h(9, 3)})
      $display("FAIL abort_newjob: valid=%b dh=%h required 1 %h", job_valid, data_hash, exp_dh(9));
    else pass++;
    take_job();
    total++;
    if (job_cnt !== 16'd6) $display("FAIL abort_cnt: got %0d required 6", job_cnt);
    else pass++;
  endtask
  task automatic test_reset_pending();
    send_job(10, 0, 0);
    send_job(11, 0, 0);
    total++;
    if (datain_ready !== 1'b0) $display("FAIL rp_pending: ready=%b required 0", datain_ready);
    else pass++;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (job_valid !== 1'b0 || job_cnt !== 16'd0 || {data_hash, midstate, target} !== '0 || datain_ready !== 1'b0)
      $display("FAIL rp_reset: valid=%b cnt=%0d ready=%b required 0 0 0", job_valid, job_cnt, datain_ready);
    else pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (datain_ready !== 1'b1 || job_valid !== 1'b0) $display("FAIL rp_release: ready=%b valid=%b required 1 0", datain_ready, job_valid);
    else pass++;
    send_job(12, 0, 0);
    total++;
    if (job_valid !== 1'b1 || {data_hash, midstate, target} !== {exp_dh(12), exp_h(12, 2), exp_h(12, 3)})
      $display("FAIL rp_after: valid=%b dh=%h required 1 %h", job_valid, data_hash, exp_dh(12));
    else pass++;
    take_job();
    total++;
    if (job_cnt !== 16'd1) $display("FAIL rp_cnt: got %0d required 1", job_cnt);
    else pass++;
  endtask
  initial begin
    test_reset();
    test_full_job();
    test_missing();
    test_back_to_back();
    test_bad_words();
    test_abort();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass, total);
    $fatal(1);
  end
endmodule

// File: doc/job_collector.md
Name: job_collector

Overview:
- Parametrised successor to the mining-job word collector.
- Assembles a header-tagged 48-bit input word stream into a complete mining job: data_hash, midstate and target.
- Adds four things: per-field completeness tracking, a shadow/output double buffer with valid/ready handoff to the hashing cores, backpressure, and error reporting.
- Sits between the host-link deserialiser and the nonce-search engines.

Parameters:
- DATAIN, 48, input word width: bit 47 = last, [46:44] = field type, [43:40] = word index, [39:0] = payload
- PAYLOAD_WID, 40, payload bits per word
- DATA_WID, 96, data_hash width (type 1)
- HASH_DATA_WID, 256, midstate (type 2) and target (type 3) width
- CNT_WID, 16, job counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- datain_valid  in  1  datain carries a word this cycle
- datain  in  DATAIN  tagged input word
- datain_ready  out  1  collector accepts a word this cycle
- job_valid  out  1  data_hash/midstate/target hold a complete job
- job_ready  in  1  consumer takes the job
- data_hash  out  DATA_WID  assembled header tail
- midstate  out  HASH_DATA_WID  assembled midstate
- target  out  HASH_DATA_WID  assembled target
- err_incomplete  out  1  one-cycle pulse: commit attempted with missing words
- err_bad_word  out  1  one-cycle pulse: illegal type/index
- job_cnt  out  CNT_WID  jobs delivered (handshakes completed), wraps

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n). All state updates on posedge clk.
- Reset: job_valid=0, datain_ready=0 during reset and 1 the cycle after, errors=0, job_cnt=0, data_hash/midstate/target=0, shadow registers and masks cleared, state COLLECT.
- Word accepted iff datain_valid && datain_ready.
- Word counts: NW_D = ceil(DATA_WID/PAYLOAD_WID) = 3; NW_H = ceil(HASH_DATA_WID/PAYLOAD_WID) = 7.
- Index k (1-based) fills shadow bits [W-1-(k-1)*P -: P], MSB-first.
- Last word carries rem = W mod P bits (16 at defaults) taken from payload[P-1 -: rem]; the low payload bits are ignored. If rem=0, the full payload is used.
- Legal types: 0 = idle (accepted, ignored), 1/2/3 = fields, 7 = abort (clears all shadow masks, no error).
- Legal index: 1..NW of that type.
- Illegal type or index: word dropped, err_bad_word pulses next cycle, shadow unchanged.
- Each legal word sets its bit in the per-field received mask. Rewriting an index overwrites the data; no error.
- Commit trigger: bit 47 set on an accepted legal type-3 word with index NW_H.
  - That word is written first, then completeness is checked on the updated masks.
  - Commit is also accepted on a legal last word of any field whose inclusion completes all three masks.
  - Commit with any mask incomplete: err_incomplete pulses, all masks cleared, nothing delivered.
- States:
  - COLLECT: datain_ready=1. On a good commit, if the output is free or being released this cycle (!job_valid || job_ready): copy shadow→outputs, job_valid=1 next cycle, clear masks, stay COLLECT. Otherwise go to PENDING.
  - PENDING: datain_ready=0; shadow frozen. When job_ready: copy shadow→outputs, keep job_valid=1, clear masks, return to COLLECT.
- Latency: commit word accepted at cycle N → job_valid and fields updated at N+1. Back-to-back jobs produce no bubble.
- Output stability: job_valid stays high and the output fields stay constant until job_valid && job_ready. Without a new commit, job_valid drops the cycle after the handshake.
- job_cnt increments on every job_valid && job_ready and wraps from 2^CNT_WID-1 to 0.
- Reset mid-job or in PENDING discards everything; behaviour is identical to power-up.
- Only bit 47 on a commit-capable word matters; bit 47 on other words is ignored.

Decomposition:
- Package job_collector_pkg holds:
  - type codes TYPE_IDLE=0, TYPE_DATA=1, TYPE_MID=2, TYPE_TGT=3, TYPE_ABORT=7
  - header bit positions
  - functions nwords(width, p) and remwidth(width, p)
  - state enum {COLLECT, PENDING}
- One natural sub-module: field_assembler, parametrised by width and type code. It owns one shadow register plus its received mask and exposes write, clear and complete. It is instantiated three times.

Test Plan:
- Full job: send data idx1..3, mid idx1..7, tgt idx1..7, with the last word carrying bit47=1 → job_valid at next cycle; target[15:0] = payload[39:24] of the last word; job_cnt 0→1 on job_ready.
- Missing word: skip mid idx4, then commit → err_incomplete pulses 1 cycle, job_valid stays 0, and a following complete job is delivered correctly.
- Backpressure: hold job_ready=0 and stream a second full job → datain_ready=0 after its commit. Assert job_ready → second job appears the next cycle with no bubble; job_cnt=2 after both handshakes.
- Illegal words: type 1 idx 4, then type 5 idx 1 → two err_bad_word pulses; shadow unchanged, verified by a later commit.
- Abort: send half a job, then type 7, then a full new job → only new-job values appear.
- Reset in PENDING: drop rst_n for 1 cycle → job_valid=0, outputs=0, job_cnt=0, datain_ready=1 the cycle after release.
